// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero register,
// optional write-to-read bypass and a sequential post-reset clear sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     ready,
  output logic                     wr_err
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              is_clear;
  logic              wr_zero;
  logic              wr_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] ra [NUM_RD];

  assign is_clear  = (state == ST_CLEAR);
  assign wr_zero   = ZERO_REG && (wr_addr == '0);
  assign wr_accept = (state == ST_RUN) && wr_en && !wr_zero;

  // Control state: sweep counter walks every entry once, then RUN until rst.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && is_clear;
      if (is_clear) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == '1) begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      end
    end
  end

  // Single write port shared between the sweep and normal writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (is_clear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (wr_accept) begin
      mem_we    = 1'b1;
    end
  end

  // NOTE: the array has no reset branch; it is cleared by the sweep so it can
  // map onto RAM macros that lack a reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign ra[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  // NOTE: rd_data gets a full default before the per-port decisions so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (is_clear) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if (ZERO_REG && (ra[k] == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if (BYPASS && wr_accept && (wr_addr == ra[k])) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem[ra[k]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default, no-bypass and small
// configurations compared against a behavioural reference model.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic        wr_en   = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [63:0] rd_data_bp, rd_data_nb;
  logic        ready_bp, wr_err_bp, ready_nb, wr_err_nb;

  logic [11:0] s_rd_addr = '0;
  logic        s_wr_en   = 1'b0;
  logic [2:0]  s_wr_addr = '0;
  logic [15:0] s_wr_data = '0;
  logic [63:0] s_rd_data;
  logic        s_ready, s_wr_err;

  regfile_mp u_bp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_bp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready_bp), .wr_err(wr_err_bp)
  );

  regfile_mp #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready_nb), .wr_err(wr_err_nb)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_small (
    .clk(clk), .rst(rst), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .ready(s_ready), .wr_err(s_wr_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: "ready" means the sweep has run DEPTH clean cycles.
  bit          m_valid = 1'b0;
  bit          m_ready, m_err;
  int          m_cnt;
  logic [31:0] m_mem [32];
  bit          s_ready_m, s_err_m;
  int          s_cnt;
  logic [15:0] s_mem [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit bp);
    if (!m_ready || a == 5'd0) return 32'h0;
    if (bp && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic [15:0] exp_s(input logic [2:0] a);
    if (!s_ready_m || a == 3'd0) return 16'h0;
    if (s_wr_en && s_wr_addr == a) return s_wr_data;
    return s_mem[a];
  endfunction

  task automatic model_update();
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b0; m_cnt = 0; m_err = 1'b0;
      s_ready_m = 1'b0; s_cnt = 0; s_err_m = 1'b0;
    end else if (m_valid) begin
      if (!m_ready) begin
        m_err = wr_en;
        m_cnt++;
        if (m_cnt == 32) begin
          m_ready = 1'b1;
          foreach (m_mem[i]) m_mem[i] = 32'h0;
        end
      end else begin
        m_err = 1'b0;
        if (wr_en && wr_addr != 5'd0) m_mem[wr_addr] = wr_data;
      end
      if (!s_ready_m) begin
        s_err_m = s_wr_en;
        s_cnt++;
        if (s_cnt == 8) begin
          s_ready_m = 1'b1;
          foreach (s_mem[i]) s_mem[i] = 16'h0;
        end
      end else begin
        s_err_m = 1'b0;
        if (s_wr_en && s_wr_addr != 3'd0) s_mem[s_wr_addr] = s_wr_data;
      end
    end
  endtask

  task automatic check_outputs();
    if (!m_valid) return;
    check("ready_bp", 32'(ready_bp), 32'(m_ready));
    check("ready_nb", 32'(ready_nb), 32'(m_ready));
    check("wr_err_bp", 32'(wr_err_bp), 32'(m_err));
    check("wr_err_nb", 32'(wr_err_nb), 32'(m_err));
    check("ready_small", 32'(s_ready), 32'(s_ready_m));
    check("wr_err_small", 32'(s_wr_err), 32'(s_err_m));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_bp%0d", k), rd_data_bp[k*32 +: 32], exp_rd(rd_addr[k*5 +: 5], 1'b1));
      check($sformatf("rd_nb%0d", k), rd_data_nb[k*32 +: 32], exp_rd(rd_addr[k*5 +: 5], 1'b0));
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd_small%0d", k), 32'(s_rd_data[k*16 +: 16]), 32'(exp_s(s_rd_addr[k*3 +: 3])));
    end
  endtask

  // Check at the falling edge, then advance the model with the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int n;

    // Reset sweep: two reset cycles, then count edges until ready.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n = 0;
    while (ready_bp !== 1'b1 && n < 100) begin
      rd_addr = 10'($urandom);
      tick();
      n++;
    end
    check("sweep_len", 32'(n), 32'd32);

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(31 - a)};
      tick();
    end

    // Write r5 and r31, read back through both ports.
    wr_en = 1'b1; wr_addr = 5'd5;  wr_data = 32'hDEADBEEF; tick();
    wr_addr = 5'd31; wr_data = 32'h12345678; tick();
    wr_en = 1'b0; rd_addr = {5'd31, 5'd5}; tick();
    check("rd_r5", rd_data_bp[31:0], 32'hDEADBEEF);
    check("rd_r31", rd_data_bp[63:32], 32'h12345678);

    // Zero register: write is discarded without an error.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0}; tick();
    wr_en = 1'b0; tick();
    check("zero_wr_err", 32'(wr_err_bp), 32'd0);
    check("zero_rd", rd_data_bp[31:0], 32'h0);

    // Same-cycle bypass versus old contents.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd5};
    #3;
    check("bypass_same", rd_data_bp[63:32], 32'hA5A5A5A5);
    check("nobypass_same", rd_data_nb[63:32], 32'h0);
    tick();
    wr_en = 1'b0; tick();
    check("nobypass_next", rd_data_nb[63:32], 32'hA5A5A5A5);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_addr = 10'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[9:5] = wr_addr;
      s_wr_en   = 1'($urandom_range(0, 1));
      s_wr_addr = 3'($urandom_range(0, 7));
      s_wr_data = 16'($urandom);
      s_rd_addr = 12'($urandom);
      tick();
    end
    rst = 1'b0; wr_en = 1'b0; s_wr_en = 1'b0;

    // Writes during the sweep are flagged and dropped.
    rst = 1'b1; tick();
    rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; rd_addr = {5'd3, 5'd3};
    for (int i = 0; i < 32; i++) begin
      tick();
      check("clear_wr_err", 32'(wr_err_bp), 32'd1);
    end
    wr_en = 1'b0; tick();
    check("clear_r3", rd_data_bp[31:0], 32'h0);
    check("clear_err_drop", 32'(wr_err_bp), 32'd0);

    // Reset mid-sweep restarts the full sweep.
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    n = 0;
    while (ready_bp !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("restart_len", 32'(n), 32'd32);

    // Small configuration: four ports reading r1, r2, r1, r0.
    s_wr_en = 1'b1; s_wr_addr = 3'd1; s_wr_data = 16'h0001; tick();
    s_wr_addr = 3'd2; s_wr_data = 16'h0002; tick();
    s_wr_en = 1'b0; s_rd_addr = {3'd0, 3'd1, 3'd2, 3'd1}; tick();
    check("small_p0", 32'(s_rd_data[15:0]), 32'h0001);
    check("small_p1", 32'(s_rd_data[31:16]), 32'h0002);
    check("small_p2", 32'(s_rd_data[47:32]), 32'h0001);
    check("small_p3", 32'(s_rd_data[63:48]), 32'h0000);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
